long_divider: RTL and testbench

LONG_DIVIDER -- requirements
Module: long_divider

---
 rtl/long_divider_pkg.sv | 24 ++
 rtl/long_divider_if.sv | 39 +++
 rtl/long_divider_div_step.sv | 42 ++++
 rtl/long_divider.sv | 136 +++++++++++++
 tb/tb_long_divider.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/long_divider_pkg.sv
// ----------------------------------------------------------------------------
// long_divider_pkg
// Shared definitions for the sequential long divider: controller state
// encoding, the default divisor width and a helper that sizes the step
// counter.
// ----------------------------------------------------------------------------
package long_divider_pkg;

    // Default divisor/remainder width; dividend and quotient are twice this.
    localparam int DEF_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The step counter must be able to hold the value 2*w once the final
    // step has been taken, hence 2*w+1 distinct values.
    function automatic int stepCountWidth(input int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/long_divider_if.sv
// ----------------------------------------------------------------------------
// long_divider_if
// Request/result bundle of the long divider.
//   istart  request strobe (taken only while oready is high)
//   ia      dividend, 2*WIDTH bits
//   ib      divisor, WIDTH bits
//   oquot   quotient, 2*WIDTH bits
//   orem    remainder, WIDTH bits
//   ovalid  one-cycle strobe marking oquot/orem/odbz as a fresh result
//   oready  divider idle and able to accept istart
//   odbz    divide-by-zero flag belonging to the current result
// The master drives requests; the slave (the divider) returns results.
// ----------------------------------------------------------------------------
interface long_divider_if
    import long_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic                 istart;
    logic [2*WIDTH-1:0]   ia;
    logic [WIDTH-1:0]     ib;
    logic [2*WIDTH-1:0]   oquot;
    logic [WIDTH-1:0]     orem;
    logic                 ovalid;
    logic                 oready;
    logic                 odbz;

    modport master (
        output istart, ia, ib,
        input  oquot, orem, ovalid, oready, odbz
    );

    modport slave (
        input  istart, ia, ib,
        output oquot, orem, ovalid, oready, odbz
    );

endinterface

// File: rtl/long_divider_div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One purely combinational iteration of restoring division.
//   prem_i     current partial remainder, WIDTH+1 bits
//   dbit_i     next dividend bit to shift in
//   divisor_i  divisor, WIDTH bits
//   prem_o     partial remainder after this iteration
//   qbit_o     quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module div_step
    import long_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   prem_i,
    input  logic             dbit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   prem_o,
    output logic             qbit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] divisorExt;
    logic             fits;

    // The shifted value is kept one bit wider than the partial remainder so
    // the comparison never loses the carried-out MSB. Because the incoming
    // remainder is always below the divisor, the shifted value stays below
    // twice the divisor and the difference fits back into WIDTH+1 bits.
    always_comb begin
        shifted    = {prem_i, dbit_i};
        divisorExt = {2'b00, divisor_i};
        fits       = (shifted >= divisorExt);
        qbit_o     = fits;
        if (fits) begin
            prem_o = shifted[WIDTH:0] - divisorExt[WIDTH:0];
        end else begin
            prem_o = shifted[WIDTH:0];
        end
    end

endmodule

// File: rtl/long_divider.sv
// ----------------------------------------------------------------------------
// long_divider
// Sequential restoring divider: a 2*WIDTH-bit dividend by a WIDTH-bit
// divisor, one quotient bit per clock, MSB first.
//   iclk  sole clock, rising edge
//   irst  synchronous active-high reset
//   bus   long_divider_if slave port (request in, result out)
// A zero divisor skips the iterations and reports an all-ones quotient,
// zero remainder and odbz=1.
// ----------------------------------------------------------------------------
module long_divider
    import long_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          iclk,
    input  logic          irst,
    long_divider_if.slave bus
);

    localparam int             QW        = 2 * WIDTH;
    localparam int             CW        = stepCountWidth(WIDTH);
    localparam logic [CW-1:0]  LAST_STEP = CW'(QW - 1);

    state_t            state_q;
    logic [QW-1:0]     a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH:0]    prem_q;
    logic [CW-1:0]     cnt_q;
    logic [QW-1:0]     qWork_q;
    logic [QW-1:0]     quot_q;
    logic [WIDTH-1:0]  rem_q;
    logic              dbz_q;
    logic              valid_q;
    logic              ready_q;

    logic [CW-1:0]     bitIdx;
    logic              dividendBit;
    logic [WIDTH:0]    prem_d;
    logic              stepQ;
    logic [QW-1:0]     quot_d;

    // The step counter walks up from zero while the dividend is consumed from
    // its MSB down, so both the dividend bit and the quotient bit position are
    // LAST_STEP - count. The captured dividend itself never shifts.
    always_comb begin
        bitIdx         = LAST_STEP - cnt_q;
        dividendBit    = a_q[bitIdx];
        quot_d         = qWork_q;
        quot_d[bitIdx] = stepQ;
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .prem_i    (prem_q),
        .dbit_i    (dividendBit),
        .divisor_i (b_q),
        .prem_o    (prem_d),
        .qbit_o    (stepQ)
    );

    // Controller, datapath registers and registered handshake outputs.
    // Results are written only on the transition into DONE and then held,
    // so the bus always shows the most recent result. oready and ovalid are
    // set from the state being entered so they line up with it exactly.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            qWork_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.istart) begin
                        a_q     <= bus.ia;
                        b_q     <= bus.ib;
                        prem_q  <= '0;
                        cnt_q   <= '0;
                        qWork_q <= '0;
                        ready_q <= 1'b0;
                        if (bus.ib == '0) begin
                            state_q <= DONE;
                            quot_q  <= '1;
                            rem_q   <= '0;
                            dbz_q   <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end

                CALC: begin
                    prem_q  <= prem_d;
                    qWork_q <= quot_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q <= DONE;
                        quot_q  <= quot_d;
                        rem_q   <= prem_d[WIDTH-1:0];
                        dbz_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.oquot  = quot_q;
    assign bus.orem   = rem_q;
    assign bus.odbz   = dbz_q;
    assign bus.ovalid = valid_q;
    assign bus.oready = ready_q;

endmodule

// File: tb/tb_long_divider.sv
// ----------------------------------------------------------------------------
// tb_long_divider
// Scoreboard bench for long_divider at the default width. Requests push the
// arithmetic expectation (plain / and %) into a queue; an independent monitor
// pops and compares whenever ovalid is seen, and also checks strobe width,
// oready during the result cycle and accept-to-result latency.
// ----------------------------------------------------------------------------
module tb_long_divider;
    import long_divider_pkg::*;

    localparam int W        = DEF_WIDTH;
    localparam int QW       = 2 * W;
    localparam int CALC_LAT = QW + 1;
    localparam int DBZ_LAT  = 1;
    localparam int AMAX     = (1 << QW) - 1;
    localparam int BMAX     = (1 << W) - 1;

    logic iclk = 1'b0;
    logic irst;

    long_divider_if #(.WIDTH(W)) bus();

    long_divider #(
        .WIDTH(W)
    ) dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus)
    );

    always #5 iclk = ~iclk;

    int edgeCount = 0;
    always @(posedge iclk) edgeCount++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [QW-1:0] quot;
        logic [W-1:0]  rem;
        logic          dbz;
        int            acceptEdge;
    } exp_t;

    exp_t sbq[$];
    bit   prevValid = 1'b0;

    // Reference: ordinary integer division; a zero divisor yields all ones.
    function automatic exp_t refModel(input int a, input int b, input int acceptEdge);
        exp_t e;
        if (b == 0) begin
            e.quot = '1;
            e.rem  = '0;
            e.dbz  = 1'b1;
        end else begin
            e.quot = QW'(a / b);
            e.rem  = W'(a % b);
            e.dbz  = 1'b0;
        end
        e.acceptEdge = acceptEdge;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a negedge; waits for oready, presents one request for a
    // single edge and reports which edge accepted it.
    task automatic applyStimulus(input int a, input int b, input bit track, output int acceptEdge);
        int waited;
        waited = 0;
        while (bus.oready !== 1'b1 && waited < 100) begin
            @(negedge iclk);
            waited++;
        end
        checkOutput("readyWait", 64'(bus.oready), 64'(1));
        bus.ia     = QW'(a);
        bus.ib     = W'(b);
        bus.istart = 1'b1;
        acceptEdge = edgeCount + 1;
        if (track) sbq.push_back(refModel(a, b, acceptEdge));
        @(negedge iclk);
        bus.istart = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge iclk);
            n++;
        end
        checkOutput("drainOutstanding", 64'(sbq.size()), 64'(0));
        sbq.delete();
    endtask

    // Monitor: sampled at the falling edge, away from the active edge.
    exp_t got;
    always @(negedge iclk) begin
        if (irst === 1'b0) begin
            if (bus.ovalid === 1'b1) begin
                checkOutput("strobeWidth", 64'(prevValid), 64'(0));
                checkOutput("readyInDone", 64'(bus.oready), 64'(0));
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedValid: got ovalid=1 with nothing outstanding, expected 0");
                end else begin
                    got = sbq.pop_front();
                    checkOutput("quotient", 64'(bus.oquot), 64'(got.quot));
                    checkOutput("remainder", 64'(bus.orem), 64'(got.rem));
                    checkOutput("dbzFlag", 64'(bus.odbz), 64'(got.dbz));
                    checkOutput("latency", 64'(edgeCount + 1 - got.acceptEdge),
                                64'(got.dbz ? DBZ_LAT : CALC_LAT));
                end
            end
            prevValid = (bus.ovalid === 1'b1);
        end else begin
            prevValid = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dA[10] = '{1023, 961, 100, 5, 0, 1023, 0, 30, 1023, 1};
        int dB[10] = '{31,   31,  7,   0, 1, 1,    31, 31, 0,    1};
        int accFirst;
        int accSecond;
        int dummy;
        int a;
        int b;

        bus.istart = 1'b0;
        bus.ia     = '0;
        bus.ib     = '0;
        irst       = 1'b1;
        repeat (3) @(negedge iclk);
        irst = 1'b0;

        checkOutput("resetReady", 64'(bus.oready), 64'(1));
        checkOutput("resetValid", 64'(bus.ovalid), 64'(0));
        checkOutput("resetDbz", 64'(bus.odbz), 64'(0));
        checkOutput("resetQuot", 64'(bus.oquot), 64'(0));
        checkOutput("resetRem", 64'(bus.orem), 64'(0));

        // Directed operands including full-scale, zero and divide-by-zero.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(dA[i], dB[i], 1'b1, dummy);
        end
        waitDrain();

        // A request during CALC must be ignored; the next one goes in at the
        // earliest legal edge, two edges after the result strobe begins.
        applyStimulus(100, 7, 1'b1, accFirst);
        @(negedge iclk);
        bus.ia     = QW'(50);
        bus.ib     = W'(3);
        bus.istart = 1'b1;
        repeat (3) @(negedge iclk);
        bus.istart = 1'b0;
        applyStimulus(50, 3, 1'b1, accSecond);
        checkOutput("backToBackEdge", 64'(accSecond - accFirst), 64'(QW + 2));
        waitDrain();

        // Reset in the middle of an operation: no strobe, reset values back.
        applyStimulus(1000, 9, 1'b0, dummy);
        repeat (3) @(negedge iclk);
        irst = 1'b1;
        @(negedge iclk);
        irst = 1'b0;
        checkOutput("abortReady", 64'(bus.oready), 64'(1));
        checkOutput("abortValid", 64'(bus.ovalid), 64'(0));
        checkOutput("abortQuot", 64'(bus.oquot), 64'(0));
        checkOutput("abortRem", 64'(bus.orem), 64'(0));
        repeat (15) @(negedge iclk);
        applyStimulus(1, 1, 1'b1, dummy);
        waitDrain();

        // Reset and request on the same edge: the request is dropped.
        irst       = 1'b1;
        bus.istart = 1'b1;
        bus.ia     = QW'(5);
        bus.ib     = W'(3);
        @(negedge iclk);
        irst       = 1'b0;
        bus.istart = 1'b0;
        checkOutput("rstPriorityReady", 64'(bus.oready), 64'(1));
        repeat (15) @(negedge iclk);

        // Randomized operand pairs with nonzero divisors.
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(AMAX, 0));
            b = int'($urandom_range(BMAX, 1));
            applyStimulus(a, b, 1'b1, dummy);
        end
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
